// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: shared definitions for the word-copy DMA engine.
//   - fabric decode window (dma_base_addr .. dma_top_addr)
//   - register offsets within the window
//   - CTRL/STATUS bit positions
//   - copy FSM state type
//   - byte-lane merge helper for strobed register writes
package dma_copy_pkg;

  localparam logic [31:0] dma_base_addr = 32'h0200_0000;
  localparam logic [31:0] dma_top_addr  = 32'h0200_000F;

  localparam logic [3:0] DMA_SRC  = 4'h0;
  localparam logic [3:0] DMA_DST  = 4'h4;
  localparam logic [3:0] DMA_LEN  = 4'h8;
  localparam logic [3:0] DMA_CTRL = 4'hC;

  // CTRL write side: start / done W1C / error W1C / ie
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_DONE  = 1;
  localparam int unsigned CTRL_ERROR = 2;
  localparam int unsigned CTRL_IE    = 3;
  // STATUS read side: busy shares bit 0 with start
  localparam int unsigned CTRL_BUSY  = 0;

  // IDLE must stay the all-zero encoding: the reset constant is a zero fill.
  typedef enum logic [2:0] {
    IDLE,
    RREQ,
    RWAIT,
    WREQ,
    WWAIT
  } dma_state_type;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// dma_copy: word-copy DMA engine.
//   Responder port (dma_*): register file SRC/DST/LEN/CTRL, base-relative
//     address, dma_ready one cycle after dma_valid, read data sampled in the
//     valid cycle.
//   Initiator port (mem_*): one outstanding request at a time; reads a word
//     from src, writes it to dst, repeated LEN times. mem_valid is a one-cycle
//     pulse, mem_wstrb 0000 for reads and 1111 for writes.
//   dma_irq: done & ie.
//   rst is synchronous, active low.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1024,
  parameter int unsigned len_width      = 16
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        dma_valid,
  input  logic        dma_instr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wstrb,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        dma_irq
);

  localparam int unsigned TW = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] TLAST = TW'(timeout_cycles - 1);

  typedef struct packed {
    dma_state_type        state;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [len_width-1:0] len;
    logic                 ie;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [31:0]          wsrc;
    logic [31:0]          wdst;
    logic [len_width-1:0] cnt;
    logic [TW-1:0]        timer;
    logic                 dma_ready;
    logic [31:0]          dma_rdata;
    logic                 mem_valid;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
  } reg_type;

  localparam reg_type init_reg = '0;

  reg_type r, v;

  logic [3:0]  off;
  logic        in_range;
  logic        reg_wr;
  logic [31:0] rd_val;
  logic [31:0] len_wr;

  logic unused_ok;
  assign unused_ok = &{1'b0, dma_instr, dma_addr[1:0]};

  always_comb begin
    v        = r;
    off      = {dma_addr[3:2], 2'b00};
    in_range = (dma_addr[31:4] == '0);
    reg_wr   = dma_valid && in_range && (dma_wstrb != '0);
    len_wr   = merge_bytes(32'(r.len), dma_wdata, dma_wstrb);
    rd_val   = '0;

    case (off)
      DMA_SRC:  rd_val = r.src;
      DMA_DST:  rd_val = r.dst;
      DMA_LEN:  rd_val = 32'(r.len);
      DMA_CTRL: rd_val = {28'd0, r.ie, r.error, r.done, r.busy};
      default:  rd_val = '0;
    endcase

    v.dma_ready = dma_valid;
    v.dma_rdata = (dma_valid && in_range) ? rd_val : '0;
    v.mem_valid = 1'b0;

    // Register writes come first so that a hardware set of done/error
    // further down overrides a same-cycle W1C from the CPU.
    if (reg_wr) begin
      case (off)
        DMA_SRC: if (!r.busy) v.src = merge_bytes(r.src, dma_wdata, dma_wstrb) & ~32'h3;
        DMA_DST: if (!r.busy) v.dst = merge_bytes(r.dst, dma_wdata, dma_wstrb) & ~32'h3;
        DMA_LEN: if (!r.busy) v.len = len_wr[len_width-1:0];
        DMA_CTRL: begin
          if (dma_wstrb[0]) begin
            v.ie = dma_wdata[CTRL_IE];
            if (dma_wdata[CTRL_DONE])  v.done  = 1'b0;
            if (dma_wdata[CTRL_ERROR]) v.error = 1'b0;
            if (dma_wdata[CTRL_START] && !r.busy) begin
              v.error = 1'b0;
              if (r.len == '0) begin
                v.done = 1'b1;
              end else begin
                v.done      = 1'b0;
                v.busy      = 1'b1;
                v.wsrc      = r.src;
                v.wdst      = r.dst;
                v.cnt       = r.len;
                v.state     = RREQ;
                v.mem_valid = 1'b1;
                v.mem_addr  = r.src;
                v.mem_wstrb = '0;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // mem_valid/mem_addr/mem_wstrb are loaded on the transition into
    // RREQ/WREQ so the registered outputs line up with those states.
    case (r.state)
      RREQ: begin
        v.state = RWAIT;
        v.timer = '0;
      end
      RWAIT: begin
        if (mem_ready) begin
          v.state     = WREQ;
          v.mem_valid = 1'b1;
          v.mem_addr  = r.wdst;
          v.mem_wdata = mem_rdata;
          v.mem_wstrb = '1;
        end else if (r.timer == TLAST) begin
          v.state = IDLE;
          v.busy  = 1'b0;
          v.error = 1'b1;
          v.done  = 1'b1;
        end else begin
          v.timer = r.timer + 1'b1;
        end
      end
      WREQ: begin
        v.state = WWAIT;
        v.timer = '0;
      end
      WWAIT: begin
        if (mem_ready) begin
          v.wsrc = r.wsrc + 32'd4;
          v.wdst = r.wdst + 32'd4;
          v.cnt  = r.cnt - 1'b1;
          if (r.cnt == len_width'(1)) begin
            v.state = IDLE;
            v.busy  = 1'b0;
            v.done  = 1'b1;
          end else begin
            v.state     = RREQ;
            v.mem_valid = 1'b1;
            v.mem_addr  = r.wsrc + 32'd4;
            v.mem_wstrb = '0;
          end
        end else if (r.timer == TLAST) begin
          v.state = IDLE;
          v.busy  = 1'b0;
          v.error = 1'b1;
          v.done  = 1'b1;
        end else begin
          v.timer = r.timer + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r <= init_reg;
    else      r <= v;
  end

  assign dma_rdata = r.dma_rdata;
  assign dma_ready = r.dma_ready;
  assign mem_valid = r.mem_valid;
  assign mem_instr = 1'b0;
  assign mem_addr  = r.mem_addr;
  assign mem_wdata = r.mem_wdata;
  assign mem_wstrb = r.mem_wstrb;
  assign dma_irq   = r.done & r.ie;

endmodule

// File: tb/tb_dma_copy.sv
module tb_dma_copy;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned LW      = 16;

  localparam logic [31:0] A_SRC  = 32'h0;
  localparam logic [31:0] A_DST  = 32'h4;
  localparam logic [31:0] A_LEN  = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_valid = 1'b0;
  logic        dma_instr = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic [3:0]  dma_wstrb = '0;
  logic [31:0] dma_rdata;
  logic        dma_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        dma_irq;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  dma_copy #(.timeout_cycles(TIMEOUT), .len_width(LW)) dut (
    .rst(rst), .clk(clk),
    .dma_valid(dma_valid), .dma_instr(dma_instr), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata),
    .dma_ready(dma_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dma_irq(dma_irq)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [logic [31:0]];
  bit          log_we[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int unsigned log_cyc[$];
  bit          pending = 0, held = 0, stray_req = 0, prev_valid = 0, pend_we = 0;
  logic [31:0] pend_addr = '0, pend_data = '0;
  int          hold_read = -1;
  int          read_cnt = 0;
  int          proto_err = 0;

  function automatic logic [31:0] peek(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (stray_req) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      stray_req = 0;
    end else if (pending) begin
      mem_ready = 1'b1;
      if (pend_we) mem_arr[pend_addr] = pend_data;
      else         mem_rdata = peek(pend_addr);
      pending = 0;
    end
    if (mem_valid) begin
      if (pending || held || prev_valid) proto_err++;
      if (mem_instr !== 1'b0 || (mem_wstrb !== 4'h0 && mem_wstrb !== 4'hF) ||
          mem_addr[1:0] !== 2'b00) proto_err++;
      pend_we   = (mem_wstrb == 4'hF);
      pend_addr = mem_addr;
      pend_data = mem_wdata;
      log_we.push_back(pend_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(pend_we ? mem_wdata : 32'h0);
      log_cyc.push_back(cyc);
      if (!pend_we && read_cnt == hold_read) held = 1;
      else pending = 1;
      if (!pend_we) read_cnt++;
    end
    prev_valid = mem_valid;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic cpu_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic rdy, output logic [31:0] q);
    @(posedge clk); #1;
    dma_valid = 1'b1; dma_addr = a; dma_wdata = d; dma_wstrb = s;
    @(posedge clk); #1;
    dma_valid = 1'b0; dma_wstrb = '0;
    rdy = dma_ready;
    q   = dma_rdata;
  endtask

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
    read_cnt = 0;
  endtask

  task automatic wait_irq(input int unsigned maxc, output int unsigned seen);
    seen = 0;
    for (int unsigned i = 0; i < maxc; i++) begin
      @(posedge clk); #2;
      if (dma_irq === 1'b1) begin
        seen = cyc;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic rdy; logic [31:0] q;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if ({dma_ready, dma_rdata, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, dma_irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h ready=%b irq=%b, required all 0",
               mem_valid, mem_addr, dma_ready, dma_irq);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_access(32'(4 * i), '0, 4'h0, rdy, q);
      checks++;
      if (rdy !== 1'b1 || q !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got ready=%b data=%h, required ready=1 data=0", i, rdy, q);
      end
    end
  endtask

  // Programs a transfer and compares the bus trace, the destination
  // contents and the completion time against a transaction-level model.
  task automatic test_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input string label);
    logic [31:0] exp_d[$];
    logic rdy; logic [31:0] q;
    int unsigned c0, seen;
    for (int i = 0; i < len; i++) exp_d.push_back(peek(src + 32'(4 * i)));
    cpu_access(A_SRC, src, 4'hF, rdy, q);
    cpu_access(A_DST, dst, 4'hF, rdy, q);
    cpu_access(A_LEN, 32'(len), 4'hF, rdy, q);
    clear_log();
    cpu_access(A_CTRL, 32'h9, 4'h1, rdy, q);
    c0 = cyc;
    wait_irq(32'(4 * len + 60), seen);
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL %s_irq_timeout: irq never rose, required within %0d cycles", label, 4 * len);
    end else if (seen - c0 != 32'(4 * len)) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", label, seen - c0, 4 * len);
    end
    checks++;
    if (log_we.size() != 2 * len) begin
      errors++;
      $display("FAIL %s_txn_count: got %0d, required %0d", label, log_we.size(), 2 * len);
    end
    for (int i = 0; i < log_we.size() && i < 2 * len; i++) begin
      logic [31:0] ea, ed;
      bit ew;
      ew = (i % 2) == 1;
      ea = (ew ? dst : src) + 32'(4 * (i / 2));
      ed = ew ? exp_d[i/2] : 32'h0;
      checks++;
      if (log_we[i] != ew || log_addr[i] !== ea || log_data[i] !== ed) begin
        errors++;
        $display("FAIL %s_txn%0d: got we=%0d addr=%h data=%h, required we=%0d addr=%h data=%h",
                 label, i, log_we[i], log_addr[i], log_data[i], ew, ea, ed);
      end
    end
    for (int i = 0; i < len; i++) begin
      checks++;
      if (peek(dst + 32'(4 * i)) !== exp_d[i]) begin
        errors++;
        $display("FAIL %s_dst%0d: got %h, required %h", label, i, peek(dst + 32'(4 * i)), exp_d[i]);
      end
    end
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'hA) begin
      errors++;
      $display("FAIL %s_status: got %h, required 0000000a", label, q);
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL %s_protocol: got %0d violations, required 0", label, proto_err);
    end
  endtask

  task automatic test_len_zero();
    logic rdy; logic [31:0] q;
    cpu_access(A_CTRL, 32'h2, 4'h1, rdy, q);
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL done_w1c: got status %h, required 00000000", q);
    end
    cpu_access(A_LEN, '0, 4'hF, rdy, q);
    clear_log();
    cpu_access(A_CTRL, 32'h1, 4'h1, rdy, q);
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h2) begin
      errors++;
      $display("FAIL len0_status: got %h, required 00000002", q);
    end
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (log_we.size() != 0) begin
      errors++;
      $display("FAIL len0_no_bus: got %0d transactions, required 0", log_we.size());
    end
  endtask

  task automatic test_timeout();
    logic rdy; logic [31:0] q;
    int unsigned seen, nw;
    cpu_access(A_SRC, 32'h300, 4'hF, rdy, q);
    cpu_access(A_DST, 32'h400, 4'hF, rdy, q);
    cpu_access(A_LEN, 32'd4, 4'hF, rdy, q);
    clear_log();
    hold_read = 1;
    cpu_access(A_CTRL, 32'h9, 4'h1, rdy, q);
    wait_irq(100, seen);
    checks++;
    if (seen == 0 || log_cyc.size() < 3) begin
      errors++;
      $display("FAIL timeout_abort: irq=%0d txns=%0d, required abort after 3 txns", seen, log_cyc.size());
    end else if (seen - log_cyc[2] != TIMEOUT + 1) begin
      // request cycle plus TIMEOUT cycles of waiting in RWAIT
      errors++;
      $display("FAIL timeout_latency: got %0d, required %0d", seen - log_cyc[2], TIMEOUT + 1);
    end
    nw = 0;
    foreach (log_we[i]) if (log_we[i]) nw++;
    checks++;
    if (nw != 1 || log_we.size() != 3) begin
      errors++;
      $display("FAIL timeout_writes: got %0d writes of %0d txns, required 1 of 3", nw, log_we.size());
    end
    cpu_access(A_CTRL, 32'h0, 4'h1, rdy, q);
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h6) begin
      errors++;
      $display("FAIL timeout_status: got %h, required 00000006", q);
    end
    held = 0;
    hold_read = -1;
    stray_req = 1;
    repeat (10) @(posedge clk);
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h6 || log_we.size() != 3) begin
      errors++;
      $display("FAIL late_ready: got status %h txns %0d, required 00000006 and 3", q, log_we.size());
    end
    cpu_access(A_CTRL, 32'h6, 4'h1, rdy, q);
    cpu_access(A_CTRL, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL error_w1c: got %h, required 00000000", q);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] exp_d[$];
    logic rdy, r1, r2, r3; logic [31:0] q;
    int unsigned seen;
    for (int i = 0; i < 4; i++) exp_d.push_back(peek(32'h500 + 32'(4 * i)));
    cpu_access(A_SRC, 32'h500, 4'hF, rdy, q);
    cpu_access(A_DST, 32'h600, 4'hF, rdy, q);
    cpu_access(A_LEN, 32'd4, 4'hF, rdy, q);
    clear_log();
    cpu_access(A_CTRL, 32'h9, 4'h1, rdy, q);
    cpu_access(A_SRC, 32'hDEAD, 4'hF, r1, q);
    cpu_access(A_CTRL, 32'h9, 4'h1, r2, q);
    cpu_access(A_LEN, 32'd7, 4'hF, r3, q);
    checks++;
    if ({r1, r2, r3} !== 3'b111) begin
      errors++;
      $display("FAIL busy_ack: got ready %b%b%b, required 111", r1, r2, r3);
    end
    wait_irq(100, seen);
    checks++;
    if (seen == 0 || log_we.size() != 8) begin
      errors++;
      $display("FAIL busy_txns: got irq=%0d txns=%0d, required completion with 8", seen, log_we.size());
    end
    for (int i = 0; i < log_we.size() && i < 8; i++) begin
      logic [31:0] ea;
      ea = ((i % 2) ? 32'h600 : 32'h500) + 32'(4 * (i / 2));
      checks++;
      if (log_addr[i] !== ea || ((i % 2) == 1 && log_data[i] !== exp_d[i/2])) begin
        errors++;
        $display("FAIL busy_txn%0d: got addr=%h data=%h, required addr=%h", i, log_addr[i], log_data[i], ea);
      end
    end
    cpu_access(A_SRC, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h500) begin
      errors++;
      $display("FAIL busy_src_kept: got %h, required 00000500", q);
    end
    cpu_access(A_LEN, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h4) begin
      errors++;
      $display("FAIL busy_len_kept: got %h, required 00000004", q);
    end
  endtask

  task automatic test_copy_random();
    for (int n = 0; n < 4; n++) begin
      logic [31:0] s;
      int len;
      s   = $urandom & ~32'h3;
      len = int'($urandom_range(1, 6));
      test_copy(s, s ^ 32'h8000_0000, len, "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic rdy; logic [31:0] q;
    bit found;
    int nw;
    cpu_access(A_SRC, 32'h700, 4'hF, rdy, q);
    cpu_access(A_DST, 32'h800, 4'hF, rdy, q);
    cpu_access(A_LEN, 32'd4, 4'hF, rdy, q);
    clear_log();
    cpu_access(A_CTRL, 32'h9, 4'h1, rdy, q);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #2;
      nw = 0;
      foreach (log_we[k]) if (log_we[k]) nw++;
      if (nw == 2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach: second write never issued, required within 100 cycles");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, dma_irq, dma_ready} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got valid=%b addr=%h irq=%b, required all 0", mem_valid, mem_addr, dma_irq);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_access(32'(4 * i), '0, 4'h0, rdy, q);
      checks++;
      if (q !== 32'h0) begin
        errors++;
        $display("FAIL rstmid_reg%0d: got %h, required 00000000", i, q);
      end
    end
    stray_req = 1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (log_we.size() != 4 || proto_err != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d txns %0d violations, required 4 and 0", log_we.size(), proto_err);
    end
  endtask

  task automatic test_regs();
    logic rdy; logic [31:0] q, exp_src, wd;
    logic [3:0] ws;
    cpu_access(A_DST, 32'h1234_5678, 4'hF, rdy, q);
    cpu_access(A_DST, 32'h00AB_0000, 4'h4, rdy, q);
    cpu_access(A_DST, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h12AB_5678) begin
      errors++;
      $display("FAIL byte_strobe: got %h, required 12ab5678", q);
    end
    cpu_access(A_SRC, 32'h103, 4'hF, rdy, q);
    cpu_access(A_SRC, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h100) begin
      errors++;
      $display("FAIL src_align: got %h, required 00000100", q);
    end
    cpu_access(A_LEN, 32'hFFFF_FFFF, 4'hF, rdy, q);
    cpu_access(A_LEN, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL len_width: got %h, required 0000ffff", q);
    end
    cpu_access(32'h14, 32'hFFFF_FFFF, 4'hF, rdy, q);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL oor_ack: got ready %b, required 1", rdy);
    end
    cpu_access(32'h14, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: got %h, required 00000000", q);
    end
    cpu_access(A_DST, '0, 4'h0, rdy, q);
    checks++;
    if (q !== 32'h12AB_5678) begin
      errors++;
      $display("FAIL oor_write_ignored: got DST %h, required 12ab5678", q);
    end
    exp_src = 32'h100;
    for (int n = 0; n < 6; n++) begin
      wd = $urandom;
      ws = 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) if (ws[b]) exp_src[8*b +: 8] = wd[8*b +: 8];
      exp_src[1:0] = 2'b00;
      cpu_access(A_SRC, wd, ws, rdy, q);
      cpu_access(A_SRC, '0, 4'h0, rdy, q);
      checks++;
      if (q !== exp_src) begin
        errors++;
        $display("FAIL rand_strobe%0d: got %h, required %h (wstrb %b)", n, q, exp_src, ws);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem_arr[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    test_reset();
    test_copy(32'h100, 32'h200, 4, "basic");
    test_len_zero();
    test_timeout();
    test_busy_writes();
    test_copy_random();
    test_copy(32'hFFFF_FFF8, 32'h0000_1000, 4, "wrap");
    test_reset_mid();
    test_regs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
